// File: rtl/eth_tx_pkt_gen.sv
// Avalon-ST Ethernet frame source for the 10G MAC TX client interface (32-bit, ready latency 0).
// Frames carry a programmable header and an incrementing-byte payload; the FCS is appended by the MAC.
module eth_tx_pkt_gen #(
    parameter int IPG_BEATS = 2,
    parameter int MIN_LEN   = 60,
    parameter int MAX_LEN   = 9596,
    parameter int CNT_W     = 32
) (
    input  logic             tx_156_25_clk,
    input  logic             tx_rst,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] num_pkts,
    input  logic [13:0]      pkt_len,
    input  logic [47:0]      dst_mac,
    input  logic [47:0]      src_mac,
    input  logic [15:0]      ethertype,
    input  logic             err_inject,
    output logic             avalon_st_tx_startofpacket,
    output logic             avalon_st_tx_endofpacket,
    output logic             avalon_st_tx_valid,
    output logic [31:0]      avalon_st_tx_data,
    output logic [1:0]       avalon_st_tx_empty,
    output logic             avalon_st_tx_error,
    input  logic             avalon_st_tx_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pkts_sent
);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

    state_t             r_state;
    logic [13:0]        r_len;
    logic [11:0]        r_nbeats;
    logic [1:0]         r_last_empty;
    logic [CNT_W-1:0]   r_num;
    logic [111:0]       r_hdr;
    logic [CNT_W-1:0]   r_pkts;
    logic [11:0]        r_beat;
    logic [15:0]        r_gap;
    logic               r_stop_seen;
    logic               r_err_pend;
    logic               r_valid;
    logic               r_sop;
    logic               r_eop;
    logic [1:0]         r_empty;
    logic               r_error;
    logic [31:0]        r_data;

    logic [13:0]        w_len_cl;
    logic [11:0]        w_nbeats_cfg;
    logic [1:0]         w_empty_cfg;
    logic               w_accept;
    logic               w_end_run;
    logic [11:0]        w_idx;
    logic               w_last;
    logic               w_load;
    logic [31:0]        w_word;

    always_comb begin
        w_len_cl = pkt_len;
        if (pkt_len < 14'(MIN_LEN))
            w_len_cl = 14'(MIN_LEN);
        else if (pkt_len > 14'(MAX_LEN))
            w_len_cl = 14'(MAX_LEN);
    end

    assign w_nbeats_cfg = 12'((15'(w_len_cl) + 15'd3) >> 2);
    assign w_empty_cfg  = 2'(3'd4 - {1'b0, w_len_cl[1:0]});

    assign w_accept  = r_valid & avalon_st_tx_ready;
    assign w_end_run = stop | r_stop_seen |
                       ((r_num != '0) && (r_pkts + CNT_W'(1) == r_num));
    // Index of the beat that gets loaded into the output registers next.
    assign w_idx  = (r_state == S_SEND && !r_eop) ? r_beat + 12'd1 : 12'd0;
    assign w_last = (w_idx == r_nbeats - 12'd1);
    assign w_load = ((r_state == S_SEND) && w_accept &&
                     (!r_eop || (!w_end_run && IPG_BEATS == 0))) ||
                    ((r_state == S_GAP) && !stop && r_gap == 16'(IPG_BEATS - 1));

    // Byte lane gi of the beat: header bytes, then (seed + k) payload, zero past the frame end.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [15:0] w_j;
            logic [6:0]  w_sh;
            logic [7:0]  w_byte;
            assign w_j    = {2'b00, w_idx, 2'b00} + 16'(gi);
            assign w_sh   = 7'd104 - {w_j[3:0], 3'b000};
            assign w_byte = (w_j >= {2'b00, r_len}) ? 8'h00 :
                            (w_j < 16'd14)          ? 8'(r_hdr >> w_sh) :
                                                      r_pkts[7:0] + w_j[7:0] - 8'd14;
            assign w_word[31-8*gi -: 8] = w_byte;
        end
    endgenerate

    always_ff @(posedge tx_156_25_clk or posedge tx_rst) begin
        if (tx_rst) begin
            r_state      <= S_IDLE;
            r_len        <= '0;
            r_nbeats     <= '0;
            r_last_empty <= '0;
            r_num        <= '0;
            r_hdr        <= '0;
            r_pkts       <= '0;
            r_gap        <= '0;
            r_stop_seen  <= 1'b0;
            r_err_pend   <= 1'b0;
        end else begin
            if (err_inject)
                r_err_pend <= 1'b1;
            else if (w_accept && r_eop && r_error)
                r_err_pend <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_len        <= w_len_cl;
                        r_nbeats     <= w_nbeats_cfg;
                        r_last_empty <= w_empty_cfg;
                        r_num        <= num_pkts;
                        r_hdr        <= {dst_mac, src_mac, ethertype};
                        r_pkts       <= '0;
                        r_stop_seen  <= 1'b0;
                        r_state      <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (stop)
                        r_stop_seen <= 1'b1;
                    if (w_accept && r_eop) begin
                        r_pkts <= r_pkts + CNT_W'(1);
                        if (w_end_run) begin
                            r_state <= S_DONE;
                        end else if (IPG_BEATS > 0) begin
                            r_gap   <= '0;
                            r_state <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (stop)
                        r_state <= S_DONE;
                    else if (r_gap == 16'(IPG_BEATS - 1))
                        r_state <= S_SEND;
                    else
                        r_gap <= r_gap + 16'd1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Output beat registers: only change when idle-to-send, on acceptance, or at the end of a gap.
    always_ff @(posedge tx_156_25_clk or posedge tx_rst) begin
        if (tx_rst) begin
            r_valid <= 1'b0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
            r_empty <= '0;
            r_error <= 1'b0;
            r_data  <= '0;
            r_beat  <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_valid <= 1'b1;
            r_sop   <= 1'b1;
            r_eop   <= 1'b0;
            r_empty <= '0;
            r_error <= 1'b0;
            r_data  <= dst_mac[47:16];
            r_beat  <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_sop   <= (w_idx == 12'd0);
            r_eop   <= w_last;
            r_empty <= w_last ? r_last_empty : 2'd0;
            r_error <= w_last & r_err_pend;
            r_data  <= w_word;
            r_beat  <= w_idx;
        end else if (w_accept) begin
            r_valid <= 1'b0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
            r_empty <= '0;
            r_error <= 1'b0;
        end
    end

    assign avalon_st_tx_startofpacket = r_sop;
    assign avalon_st_tx_endofpacket   = r_eop;
    assign avalon_st_tx_valid         = r_valid;
    assign avalon_st_tx_data          = r_data;
    assign avalon_st_tx_empty         = r_empty;
    assign avalon_st_tx_error         = r_error;
    assign busy                       = (r_state != S_IDLE);
    assign done                       = (r_state == S_DONE);
    assign pkts_sent                  = r_pkts;

endmodule

// File: doc/eth_tx_pkt_gen.md
Name: eth_tx_pkt_gen

Overview:
Avalon-ST packet source that drives the 32-bit TX client interface of the 10G MAC: the avalon_st_tx_* sink with startofpacket, endofpacket, empty, error and ready. It generates Ethernet frames with a programmable header and length and an incrementing-byte payload, for loopback and bring-up traffic. The MAC appends the FCS, so generated frames exclude it. Control is by level/pulse inputs driven from a CSR block.

Parameters:
IPG_BEATS, 2, idle cycles (valid low) inserted between consecutive frames
MIN_LEN, 60, minimum frame length in bytes (excl. FCS); shorter requests are clamped up
MAX_LEN, 9596, maximum frame length in bytes; longer requests are clamped down
CNT_W, 32, width of packet count and sent counter

Ports:
tx_156_25_clk  in  1  clock; all logic on this clock
tx_rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; latches config and begins a run (ignored unless IDLE)
stop  in  1  one-cycle pulse; finish current frame, then return to IDLE
num_pkts  in  CNT_W  frames to send; 0 = continuous until stop
pkt_len  in  14  frame length in bytes excl. FCS
dst_mac  in  48  destination MAC
src_mac  in  48  source MAC
ethertype  in  16  type/length field
err_inject  in  1  pulse; next EOP beat sent carries avalon_st_tx_error=1 (one frame only)
avalon_st_tx_startofpacket  out  1  first beat of frame
avalon_st_tx_endofpacket  out  1  last beat of frame
avalon_st_tx_valid  out  1  beat valid
avalon_st_tx_data  out  32  beat data; first byte on wire in [31:24]
avalon_st_tx_empty  out  2  unused bytes on EOP beat (low-order bytes)
avalon_st_tx_error  out  1  frame error, asserted only with EOP
avalon_st_tx_ready  in  1  MAC ready, ready latency 0
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse on return to IDLE
pkts_sent  out  CNT_W  frames completed since last start

Behaviour:
- Reset: all outputs 0; FSM IDLE; err_inject pending flag cleared.
- Config (clamped length L, num_pkts, MACs, ethertype) latched on start in IDLE; changes mid-run are ignored.
- Beat accepted when valid && ready. While valid && !ready, data, sop, eop, empty and error are held stable. Valid is never withdrawn before acceptance.
- Beats per frame N = ceil(L/4). empty = (4 - L mod 4) mod 4 on the EOP beat, 0 otherwise.
- Byte stream: DA[47:0] MSB first, SA[47:0], ethertype[15:8], ethertype[7:0], then payload byte k = (seed + k) mod 256, where seed = pkts_sent[7:0] at frame start.
- Beat 0 = DA[47:16]; beat 1 = {DA[15:0], SA[47:32]}; beat 2 = SA[31:0]; beat 3 = {ethertype, payload0, payload1}; later beats carry four payload bytes. Bytes past L on the EOP beat are 0.
- FSM:
  - IDLE: start -> SEND (pkts_sent cleared, beat index 0).
  - SEND: valid=1; on the accepted EOP beat pkts_sent++, then:
    - if stop was seen during the run, or (num_pkts!=0 and pkts_sent+1==num_pkts) -> DONE;
    - else if IPG_BEATS>0 -> GAP;
    - else -> SEND with sop on the next cycle.
  - GAP: valid=0 for IPG_BEATS cycles -> SEND. A stop arriving in GAP -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- The first SOP beat appears the cycle after start (registered outputs); no gap before the first frame.
- stop in IDLE is ignored. stop and start in the same IDLE cycle: start wins and stop is dropped. stop on the EOP-accept cycle ends the run after that frame.
- err_inject sets a pending flag. The flag applies to the first EOP beat presented after it was set and clears when that beat is accepted. err_inject on the EOP cycle itself applies to the next frame.
- pkts_sent wraps at 2^CNT_W. Continuous mode never terminates on wrap.
- Async reset mid-frame: valid drops immediately and the frame is truncated. The MAC side tolerates this through its own reset.

Test Plan:
- pkt_len=64, num_pkts=1, DA=00_11_22_33_44_55, SA=66_77_88_99_AA_BB, type=0x0800, ready=1 -> 16 beats; beat0 0x00112233, beat1 0x445566 77, beat2 0x8899AABB, beat3 0x08000001, eop on beat 15 with empty=0; done pulse; pkts_sent=1.
- pkt_len=61 and 63 -> 16 beats, empty=3 and 1 respectively; pkt_len=10 is clamped to 60 -> 15 beats, empty=0; pkt_len=12000 is clamped to 9596 -> 2399 beats.
- Random ready backpressure (50%), num_pkts=5, len=100 -> data held stable while stalled; 5 SOP/EOP pairs; IPG_BEATS idle cycles between frames; payload seeds 0..4.
- num_pkts=0, stop pulsed mid-frame 3 -> frame 3 completes intact, then done; pkts_sent=4 (frames 0..3).
- err_inject pulsed during frame 1 of 3 -> error=1 only on frame 1's EOP beat; frames 0 and 2 have error=0.
- tx_rst asserted mid-frame -> valid=0 and busy=0 the same cycle; after release, start gives a clean frame with seed 0.
